// File: rtl/mux4_reg_if.sv
// mux4_reg_if: data/select/valid bundle for mux4_reg; out_par exists only when MUX4_PARITY_EN is defined
interface mux4_reg_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0] a, b, c, d, out;
    logic [1:0] sel, sel_q;
    logic in_valid, out_valid;
`ifdef MUX4_PARITY_EN
    logic out_par;
`endif
    modport master (
        output a, b, c, d, sel, in_valid,
`ifdef MUX4_PARITY_EN
        input out_par,
`endif
        input out, out_valid, sel_q
    );
    modport slave (
        input a, b, c, d, sel, in_valid,
`ifdef MUX4_PARITY_EN
        output out_par,
`endif
        output out, out_valid, sel_q
    );
endinterface

// File: rtl/mux4_reg.sv
// mux4_reg: registered 4:1 selector with valid and select echo; MUX4_PARITY_EN adds a registered parity bit
module mux4_reg #(
    parameter int WIDTH = 1
) (
    input logic clk,
    input logic rst_n,
    mux4_reg_if.slave bus
);
    logic [WIDTH-1:0] picked;
    // pure combinational pick ahead of the output register
    always_comb picked = bus.sel[1] ? (bus.sel[0] ? bus.d : bus.c) : (bus.sel[0] ? bus.b : bus.a);
    // capture on in_valid, otherwise hold data/select and drop valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out <= '0;
            bus.sel_q <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out <= picked;
                bus.sel_q <= bus.sel;
            end
        end
    end
`ifdef MUX4_PARITY_EN
    // parity of the selected word follows the same capture/hold rules as out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.out_par <= 1'b0;
        else if (bus.in_valid) bus.out_par <= ^picked;
    end
`endif
endmodule

// File: tb/tb_mux4_reg.sv
// tb_mux4_reg: scoreboard bench for mux4_reg with directed, hand-computed vectors
module tb_mux4_reg;
    typedef struct {
        logic v;
        logic [7:0] d;
        logic [1:0] s;
        logic p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    exp_t q[$];
    logic [7:0] last_d = '0;
    logic [1:0] last_s = '0;
    logic last_p = 1'b0;

    mux4_reg_if #(.WIDTH(8)) bus();
    mux4_reg #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle of stimulus; for a capture the expected word/parity are supplied by hand
    task automatic drive(input logic [7:0] va, vb, vc, vd, input logic [1:0] s, input logic v,
                         input logic [7:0] ed, input logic ep);
        exp_t e;
        @(negedge clk);
        bus.a = va; bus.b = vb; bus.c = vc; bus.d = vd; bus.sel = s; bus.in_valid = v;
        if (v) begin
            last_d = ed; last_s = s; last_p = ep;
        end
        e.v = v; e.d = last_d; e.s = last_s; e.p = last_p;
        q.push_back(e);
    endtask

    // monitor: one scoreboard entry per driven cycle, sampled 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_valid", 32'(bus.out_valid), 32'(e.v));
                check("out", 32'(bus.out), 32'(e.d));
                check("sel_q", 32'(bus.sel_q), 32'(e.s));
`ifdef MUX4_PARITY_EN
                check("out_par", 32'(bus.out_par), 32'(e.p));
`endif
            end
        end
    end

    initial begin
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.sel = '0; bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_sel_q", 32'(bus.sel_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // select sweep, back-to-back
        drive(8'h00, 8'h01, 8'h00, 8'h01, 2'd0, 1'b1, 8'h00, 1'b0);
        drive(8'h00, 8'h01, 8'h00, 8'h01, 2'd1, 1'b1, 8'h01, 1'b1);
        drive(8'h00, 8'h01, 8'h00, 8'h01, 2'd2, 1'b1, 8'h00, 1'b0);
        drive(8'h00, 8'h01, 8'h00, 8'h01, 2'd3, 1'b1, 8'h01, 1'b1);
        // repeated select
        drive(8'h00, 8'h01, 8'h00, 8'h01, 2'd0, 1'b1, 8'h00, 1'b0);
        drive(8'h00, 8'h01, 8'h00, 8'h01, 2'd0, 1'b1, 8'h00, 1'b0);
        // wide data
        drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd2, 1'b1, 8'h33, 1'b0);
        drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd3, 1'b1, 8'h44, 1'b0);
        // parity vectors
        drive(8'h11, 8'h22, 8'h33, 8'h07, 2'd3, 1'b1, 8'h07, 1'b1);
        drive(8'h11, 8'h03, 8'h33, 8'h07, 2'd1, 1'b1, 8'h03, 1'b0);
        // hold: capture b=1, then change everything with in_valid low
        drive(8'h00, 8'h01, 8'h00, 8'h01, 2'd1, 1'b1, 8'h01, 1'b1);
        drive(8'hf0, 8'h00, 8'h5a, 8'h0f, 2'd0, 1'b0, 8'h00, 1'b0);
        drive(8'hf0, 8'h00, 8'h5a, 8'h0f, 2'd2, 1'b0, 8'h00, 1'b0);
        // async reset mid-cycle with out=1 held
        @(posedge clk);
        #3;
        check("pre_rst_out", 32'(bus.out), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(bus.out), 32'h0);
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_sel_q", 32'(bus.sel_q), 32'h0);
        last_d = '0; last_s = '0; last_p = 1'b0;
        // capture request during reset must be discarded
        @(negedge clk);
        bus.a = 8'h00; bus.b = 8'h00; bus.c = 8'h00; bus.d = 8'hff; bus.sel = 2'd3; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        drive(8'h00, 8'h00, 8'h00, 8'hff, 2'd3, 1'b0, 8'h00, 1'b0);
        // fresh capture after reset
        drive(8'h00, 8'h00, 8'h33, 8'hff, 2'd2, 1'b1, 8'h33, 1'b0);
        drive(8'h00, 8'h00, 8'h33, 8'hff, 2'd2, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
